// File: rtl/countdown_sequencer.sv
// countdown_sequencer: control stage in front of the MAX7219 8x8 matrix driver.
// On start it counts down once per tick on `digit`. It then waits for a game
// result and shows the matching smiley code (10 happy, 11 neutral, 12 sad) for
// SHOW_TICKS ticks.
// Optional feature: define COUNTDOWN_BLINK_EN to blink the display while waiting
// for the result.
module countdown_sequencer #(
  parameter int unsigned TICK_CYCLES   = 1000000,
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter int unsigned SHOW_TICKS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] start_value,
  input  logic       abort,
  input  logic       result_valid,
  input  logic [1:0] result,
  output logic [3:0] digit,
  output logic       display_active,
  output logic       busy,
  output logic       done
);

  localparam int unsigned TW = $clog2(TICK_CYCLES);

  localparam logic [3:0] CODE_HAPPY   = 4'd10;
  localparam logic [3:0] CODE_NEUTRAL = 4'd11;
  localparam logic [3:0] CODE_SAD     = 4'd12;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COUNT       = 2'd1,
    WAIT_RESULT = 2'd2,
    SHOW_RESULT = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    tick_num;

  logic       tick_c;
  logic [7:0] tick_num_inc_c;
  logic [3:0] start_clamp_c;
  logic [3:0] smiley_c;

  assign tick_c         = (tick_cnt == TW'(TICK_CYCLES - 1));
  assign tick_num_inc_c = tick_num + 8'd1;
  assign start_clamp_c  = (start_value > 4'd9) ? 4'd9 : start_value;

  // Result to smiley code; result 3 is treated as neutral.
  always_comb begin
    smiley_c = CODE_NEUTRAL;
    case (result)
      2'd0:    smiley_c = CODE_HAPPY;
      2'd2:    smiley_c = CODE_SAD;
      default: smiley_c = CODE_NEUTRAL;
    endcase
  end

  // Sequencer state, tick counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      digit          <= 4'd0;
      display_active <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      tick_cnt       <= '0;
      tick_num       <= 8'd0;
    end else begin
      done     <= 1'b0;
      tick_cnt <= tick_c ? '0 : tick_cnt + TW'(1);

      if (abort) begin
        state          <= IDLE;
        display_active <= 1'b0;
        busy           <= 1'b0;
        tick_cnt       <= '0;
        tick_num       <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state          <= COUNT;
              digit          <= start_clamp_c;
              display_active <= 1'b1;
              busy           <= 1'b1;
              tick_cnt       <= '0;
              tick_num       <= 8'd0;
            end
          end

          COUNT: begin
            if (tick_c) begin
              if (digit == 4'd0) begin
                state          <= WAIT_RESULT;
                display_active <= 1'b1;
                tick_cnt       <= '0;
                tick_num       <= 8'd0;
              end else begin
                digit <= digit - 4'd1;
              end
            end
          end

          WAIT_RESULT: begin
            if (result_valid) begin
              state          <= SHOW_RESULT;
              digit          <= smiley_c;
              display_active <= 1'b1;
              tick_cnt       <= '0;
              tick_num       <= 8'd0;
            end else if (tick_c) begin
              if (tick_num_inc_c == 8'(TIMEOUT_TICKS)) begin
                state          <= SHOW_RESULT;
                digit          <= CODE_SAD;
                display_active <= 1'b1;
                tick_cnt       <= '0;
                tick_num       <= 8'd0;
              end else begin
                tick_num <= tick_num_inc_c;
`ifdef COUNTDOWN_BLINK_EN
                display_active <= ~display_active;
`else
                display_active <= 1'b1;
`endif
              end
            end
          end

          SHOW_RESULT: begin
            if (tick_c) begin
              if (tick_num_inc_c == 8'(SHOW_TICKS)) begin
                state          <= IDLE;
                display_active <= 1'b0;
                busy           <= 1'b0;
                done           <= 1'b1;
                tick_cnt       <= '0;
                tick_num       <= 8'd0;
              end else begin
                tick_num <= tick_num_inc_c;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Self-checking bench for countdown_sequencer with TICK_CYCLES=4,
// TIMEOUT_TICKS=3, SHOW_TICKS=2. Expected output words are queued per cycle
// and compared after each rising edge.
module tb_countdown_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] start_value;
  logic       abort;
  logic       result_valid;
  logic [1:0] result;
  logic [3:0] digit;
  logic       display_active;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  logic [6:0] sb[$];
  logic [6:0] exp_v;
  logic [6:0] obs;

  assign obs = {digit, display_active, busy, done};

  countdown_sequencer #(
    .TICK_CYCLES  (4),
    .TIMEOUT_TICKS(3),
    .SHOW_TICKS   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .start_value   (start_value),
    .abort         (abort),
    .result_valid  (result_valid),
    .result        (result),
    .digit         (digit),
    .display_active(display_active),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

`ifdef COUNTDOWN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  function automatic logic [6:0] pk(input int d, input bit a, input bit b, input bit dn);
    return {4'(d), a, b, dn};
  endfunction

  // Display enable in WAIT_RESULT, n cycles after entry.
  function automatic bit wait_disp(input int n);
    return BLINK ? (((n / 4) % 2) == 0) : 1'b1;
  endfunction

  task automatic test_reset();
    start = 0; start_value = 0; abort = 0; result_valid = 0; result = 0;
    rst = 1;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) rst = 0;
      sb.push_back(pk(0, 0, 0, 0));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_countdown();
    logic [6:0] e;
    for (int i = 0; i < 28; i++) begin
      start        = (i == 0);
      start_value  = 4'd3;
      result_valid = (i == 18);
      result       = 2'd0;
      if (i < 16)       e = pk(3 - i / 4, 1, 1, 0);
      else if (i < 18)  e = pk(0, 1, 1, 0);
      else if (i < 26)  e = pk(10, 1, 1, 0);
      else if (i == 26) e = pk(10, 0, 0, 1);
      else              e = pk(10, 0, 0, 0);
      sb.push_back(e);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL countdown cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    result_valid = 0;
  endtask

  task automatic test_clamp_timeout();
    logic [6:0] e;
    for (int i = 0; i < 62; i++) begin
      start        = (i == 0);
      start_value  = 4'd12;
      result_valid = (i == 5);
      result       = 2'd0;
      if (i < 40)       e = pk(9 - i / 4, 1, 1, 0);
      else if (i < 52)  e = pk(0, wait_disp(i - 40), 1, 0);
      else if (i < 60)  e = pk(12, 1, 1, 0);
      else if (i == 60) e = pk(12, 0, 0, 1);
      else              e = pk(12, 0, 0, 0);
      sb.push_back(e);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL clamp_timeout_blink cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    result_valid = 0;
  endtask

  task automatic test_priority();
    logic [6:0] e;
    for (int i = 0; i < 40; i++) begin
      start        = (i == 0) || (i == 25);
      start_value  = 4'd0;
      result_valid = (i == 16) || (i == 30);
      result       = (i < 20) ? 2'd1 : 2'd3;
      if (i < 4)        e = pk(0, 1, 1, 0);
      else if (i < 16)  e = pk(0, wait_disp(i - 4), 1, 0);
      else if (i < 24)  e = pk(11, 1, 1, 0);
      else if (i == 24) e = pk(11, 0, 0, 1);
      else if (i < 30)  e = pk(0, 1, 1, 0);
      else if (i < 38)  e = pk(11, 1, 1, 0);
      else if (i == 38) e = pk(11, 0, 0, 1);
      else              e = pk(11, 0, 0, 0);
      sb.push_back(e);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL priority cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    start = 0; result_valid = 0;
  endtask

  task automatic test_abort_reset();
    logic [6:0] e;
    for (int i = 0; i < 20; i++) begin
      start        = (i == 0) || (i == 2) || (i == 10);
      start_value  = (i == 2) ? 4'd7 : ((i < 10) ? 4'd3 : 4'd0);
      abort        = (i == 5);
      result_valid = (i == 15);
      result       = 2'd2;
      rst          = (i == 17);
      if (i < 4)       e = pk(3, 1, 1, 0);
      else if (i < 5)  e = pk(2, 1, 1, 0);
      else if (i < 10) e = pk(2, 0, 0, 0);
      else if (i < 15) e = pk(0, 1, 1, 0);
      else if (i < 17) e = pk(12, 1, 1, 0);
      else             e = pk(0, 0, 0, 0);
      sb.push_back(e);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL abort_reset cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    start = 0; abort = 0; result_valid = 0; rst = 0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_clamp_timeout();
    test_priority();
    test_abort_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
